// File: rtl/mig_seq_eval_if.sv
// Bus bundle for mig_seq_eval: config port, input handshake and result handshake.
// With MIG_INV_EN defined, cfg_data gains three operand-complement bits on top.
interface mig_seq_eval_if #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 6
);
    localparam int SEL_W = $clog2(N_IN + N_NODES + 1);
    localparam int AW    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
`ifdef MIG_INV_EN
    localparam int CFG_W = 3 * SEL_W + 3;
`else
    localparam int CFG_W = 3 * SEL_W;
`endif

    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [CFG_W-1:0]   cfg_data;
    logic               cfg_drop;
    logic               in_valid;
    logic               in_ready;
    logic [N_IN-1:0]    x;
    logic               out_valid;
    logic               out_ready;
    logic               out;
    logic [N_NODES-1:0] nodes;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, x, out_ready,
        input  cfg_drop, in_ready, out_valid, out, nodes
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, x, out_ready,
        output cfg_drop, in_ready, out_valid, out, nodes
    );
endinterface

// File: rtl/mig_seq_eval.sv
// Sequential majority-of-three network evaluator: one node per cycle in index order.
// Optional MIG_INV_EN adds a per-operand complement bit to every config entry.
module mig_seq_eval #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mig_seq_eval_if.slave  bus
);
    localparam int SEL_W = $clog2(N_IN + N_NODES + 1);
    localparam int AW    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
`ifdef MIG_INV_EN
    localparam int CFG_W = 3 * SEL_W + 3;
`else
    localparam int CFG_W = 3 * SEL_W;
`endif

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   cfg_mem [N_NODES];
    logic [N_IN-1:0]    x_q;
    logic [N_NODES-1:0] node_q;
    logic [AW-1:0]      cnt_q;
    logic               drop_q;
    logic               cfg_ok, cfg_wr, accept, last_node;
    logic [CFG_W-1:0]   entry;
    logic               opa, opb, opc, node_val;

    // Only earlier nodes are visible to node k; self/forward and out-of-range selects read 0.
    function automatic logic operand(input logic [SEL_W-1:0] sel, input logic [AW-1:0] k,
                                     input logic [N_IN-1:0] xv, input logic [N_NODES-1:0] nv);
        logic v;
        v = 1'b0;
        for (int i = 0; i < N_IN; i++)
            if (int'(sel) == i + 1) v = xv[i];
        for (int j = 0; j < N_NODES; j++)
            if (int'(sel) == N_IN + 1 + j && j < int'(k)) v = nv[j];
        return v;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign cfg_ok    = (state_q == IDLE) && (int'(bus.cfg_addr) < N_NODES);
    assign cfg_wr    = bus.cfg_we && cfg_ok;
    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign last_node = (int'(cnt_q) == N_NODES - 1);

    always_comb begin
        entry = cfg_mem[cnt_q];
        opa   = operand(entry[SEL_W-1:0],         cnt_q, x_q, node_q);
        opb   = operand(entry[2*SEL_W-1:SEL_W],   cnt_q, x_q, node_q);
        opc   = operand(entry[3*SEL_W-1:2*SEL_W], cnt_q, x_q, node_q);
`ifdef MIG_INV_EN
        opa   = opa ^ entry[3*SEL_W];
        opb   = opb ^ entry[3*SEL_W+1];
        opc   = opc ^ entry[3*SEL_W+2];
`endif
        node_val = maj3(opa, opb, opc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = EVAL;
            EVAL:    if (last_node)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE) && rst_n;
        bus.out_valid = (state_q == DONE);
        bus.out       = node_q[N_NODES-1];
        bus.nodes     = node_q;
        bus.cfg_drop  = drop_q;
    end

    // A write in the same cycle as the accept lands first, so the new entry is evaluated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NODES; i++) cfg_mem[i] <= '0;
            x_q    <= '0;
            node_q <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= bus.cfg_we && !cfg_ok;
            if (cfg_wr) cfg_mem[bus.cfg_addr] <= bus.cfg_data;
            if (accept) begin
                x_q   <= bus.x;
                cnt_q <= '0;
            end
            if (state_q == EVAL) begin
                node_q[cnt_q] <= node_val;
                cnt_q         <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mig_seq_eval.sv
// Directed bench for mig_seq_eval with a table-driven network model and per-cycle compare.
module tb_mig_seq_eval;
    localparam int N_IN    = 7;
    localparam int N_NODES = 6;
    localparam int SEL_W   = $clog2(N_IN + N_NODES + 1);
`ifdef MIG_INV_EN
    localparam int CFG_W = 3 * SEL_W + 3;
`else
    localparam int CFG_W = 3 * SEL_W;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mig_seq_eval_if #(.N_IN(N_IN), .N_NODES(N_NODES)) bus ();
    mig_seq_eval #(.N_IN(N_IN), .N_NODES(N_NODES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Model state: 0 idle, 1 busy, 2 done
    logic [CFG_W-1:0]   m_tbl [N_NODES];
    logic [N_NODES-1:0] m_nodes, m_pend;
    int                 m_st = 0, m_wait = 0;
    bit                 m_known = 0;
    logic               m_drop = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CFG_W-1:0] mk(input int a, input int b, input int c);
        logic [CFG_W-1:0] e;
        e = '0;
        e[SEL_W-1:0]         = SEL_W'(a);
        e[2*SEL_W-1:SEL_W]   = SEL_W'(b);
        e[3*SEL_W-1:2*SEL_W] = SEL_W'(c);
        return e;
    endfunction

    function automatic logic [N_NODES-1:0] model_eval(input logic [N_IN-1:0] xv);
        logic [N_NODES-1:0] n;
        n = '0;
        for (int k = 0; k < N_NODES; k++) begin
            int ones;
            ones = 0;
            for (int o = 0; o < 3; o++) begin
                logic [CFG_W-1:0]   sh;
                logic [N_IN-1:0]    tx;
                logic [N_NODES-1:0] tn;
                int                 sel;
                logic               v;
                sh  = m_tbl[k] >> (o * SEL_W);
                sel = int'(sh[SEL_W-1:0]);
                v   = 1'b0;
                if (sel >= 1 && sel <= N_IN) begin
                    tx = xv >> (sel - 1);
                    v  = tx[0];
                end else if (sel > N_IN && sel <= N_IN + N_NODES && (sel - N_IN - 1) < k) begin
                    tn = n >> (sel - N_IN - 1);
                    v  = tn[0];
                end
`ifdef MIG_INV_EN
                sh = m_tbl[k] >> (3 * SEL_W + o);
                v  = v ^ sh[0];
`endif
                if (v) ones++;
            end
            n[k] = (ones >= 2);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known = 1;
            m_st    = 0;
            m_nodes = '0;
            m_drop  = 1'b0;
            for (int i = 0; i < N_NODES; i++) m_tbl[i] = '0;
        end else begin
            m_drop = bus.cfg_we && (m_st != 0 || int'(bus.cfg_addr) >= N_NODES);
            case (m_st)
                0: begin
                    if (bus.cfg_we && int'(bus.cfg_addr) < N_NODES) m_tbl[bus.cfg_addr] = bus.cfg_data;
                    if (bus.in_valid) begin
                        m_pend = model_eval(bus.x);
                        m_wait = N_NODES;
                        m_st   = 1;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_st    = 2;
                        m_nodes = m_pend;
                    end
                end
                default: if (bus.out_ready) m_st = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("cmp_in_ready", bus.in_ready, (m_st == 0) && rst_n);
            check("cmp_out_valid", bus.out_valid, m_st == 2);
            check("cmp_cfg_drop", bus.cfg_drop, m_drop);
            if (m_st != 1) begin
                check("cmp_nodes", bus.nodes, m_nodes);
                check("cmp_out", bus.out, m_nodes[N_NODES-1]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int addr, input logic [CFG_W-1:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = addr[2:0];
        bus.cfg_data = data;
        step();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start(input logic [N_IN-1:0] xv);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic finish(input string name, input logic [N_NODES-1:0] exp, input int stall, input int lat);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
        check({name, "_latency"}, n, lat);
        check({name, "_nodes"}, bus.nodes, exp);
        check({name, "_out"}, bus.out, exp[N_NODES-1]);
        for (int s = 0; s < stall; s++) begin
            step();
            check({name, "_stall_valid"}, bus.out_valid, 1);
            check({name, "_stall_ready"}, bus.in_ready, 0);
            check({name, "_stall_out"}, bus.out, exp[N_NODES-1]);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({name, "_valid_drop"}, bus.out_valid, 0);
    endtask

    task automatic run_vec(input string name, input logic [N_IN-1:0] xv, input logic [N_NODES-1:0] exp,
                           input int stall);
        start(xv);
        finish(name, exp, stall, N_NODES);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_nodes", bus.nodes, 0);
        check("rst_cfg_drop", bus.cfg_drop, 0);

        cfg_write(0, mk(1, 5, 6));
        cfg_write(1, mk(5, 6, 7));
        cfg_write(2, mk(1, 2, 3));
        cfg_write(3, mk(2, 3, 8));
        cfg_write(4, mk(1, 4, 11));
        cfg_write(5, mk(9, 10, 12));

        run_vec("all_ones", 7'h7F, 6'h3F, 0);
        run_vec("all_zero", 7'h00, 6'h00, 0);
        run_vec("mixed_a", 7'b0110001, 6'b000011, 0);
        run_vec("mixed_b_stall", 7'b0110111, 6'h3F, 5);

        // Write during EVAL must be dropped with a single-cycle pulse
        start(7'h7F);
        step();
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd5;
        bus.cfg_data = '0;
        step();
        bus.cfg_we   = 1'b0;
        check("eval_drop_pulse", bus.cfg_drop, 1);
        step();
        check("eval_drop_end", bus.cfg_drop, 0);
        finish("eval_write", 6'h3F, 0, 3);
        run_vec("after_drop", 7'h7F, 6'h3F, 0);

        cfg_write(6, mk(0, 0, 0));
        check("addr_range_drop", bus.cfg_drop, 1);
        run_vec("after_range", 7'h7F, 6'h3F, 0);

        // Write and accept in the same cycle: evaluation sees the new node 5
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 3'd5;
        bus.cfg_data = mk(1, 1, 1);
        start(7'b0000001);
        bus.cfg_we   = 1'b0;
        finish("same_cycle_wr", 6'h20, 0, N_NODES);
        cfg_write(5, mk(9, 10, 12));

`ifdef MIG_INV_EN
        cfg_write(0, mk(0, 1, 2) | (CFG_W'(1) << (3 * SEL_W)));
        run_vec("inv_x00", 7'h00, 6'h00, 0);
        run_vec("inv_x01", 7'h01, 6'h01, 0);
        cfg_write(0, mk(1, 5, 6));
`endif

        cfg_write(2, mk(11, 11, 1));
        run_vec("fwd_ref", 7'h7F, 6'h3B, 0);

        start(7'h7F);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_nodes", bus.nodes, 0);
        run_vec("cleared_cfg", 7'h7F, 6'h00, 0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
